// File: rtl/alu_unit_arbiter_pkg.sv
// Shared constants and types for the ALU-unit round-robin arbiter.
// Holds the FSM state encoding and the index-to-one-hot decoder.
package alu_unit_arbiter_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/alu_unit_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, find the first set
// bit, then rotate the resulting offset back into an absolute index.
module rr_priority_pick
   import alu_unit_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req_i[IDX_W'(i) + ptr_i];
      end
      // Scan from the top down so the lowest offset set bit wins.
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      idx_o = off + ptr_i;
      any_o = |req_i;
   end

endmodule

// File: rtl/alu_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU unit among 8 requesters.
// Grant is held until done, request withdrawal, or watchdog expiry.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no grant; pick next requester starting at ptr
//   ST_GRANT   | grant held; watchdog counting
//   ST_RELEASE | one-cycle turnaround with grant dropped; ptr advances
module alu_unit_arbiter
   import alu_unit_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic             done_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o,
   output logic             busy_o,
   output logic             timeout_o
);

   localparam logic             WD_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic             valid_q;
   logic             busy_q;
   logic             timeout_q;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             normal_rel;
   logic             wd_expire;

   rr_priority_pick u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // done has priority over the watchdog when both occur together.
   assign normal_rel = done_i | ~req_i[idx_q];
   assign wd_expire  = WD_EN & (cnt_q == WD_LAST);
   assign ptr_d      = idx_q + IDX_W'(1);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q <= ST_GRANT;
                  idx_q   <= pick_idx;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_GRANT: begin
               if (normal_rel) begin
                  state_q <= ST_RELEASE;
                  valid_q <= 1'b0;
               end else if (wd_expire) begin
                  state_q   <= ST_RELEASE;
                  valid_q   <= 1'b0;
                  timeout_q <= 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               ptr_q   <= ptr_d;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o       = valid_q ? idx_to_onehot(idx_q) : '0;
   assign gnt_idx_o   = idx_q;
   assign gnt_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_alu_unit_arbiter.sv
// Directed bench for alu_unit_arbiter with a grant-index scoreboard.
module tb_alu_unit_arbiter;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic [7:0] req_i;
   logic       done_i;
   logic [7:0] gnt_o;
   logic [2:0] gnt_idx_o;
   logic       gnt_valid_o;
   logic       busy_o;
   logic       timeout_o;

   int n_chk  = 0;
   int n_pass = 0;
   logic [2:0] exp_q[$];

   always #5 clock_i = ~clock_i;

   alu_unit_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .req_i       (req_i),
      .done_i      (done_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o)
   );

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_idle_out(input string tag, input logic [2:0] exp_idx,
                               input logic exp_busy, input logic exp_to);
      chk({tag, "_gnt"}, {24'd0, gnt_o}, 32'h0);
      chk({tag, "_valid"}, {31'd0, gnt_valid_o}, 32'h0);
      chk({tag, "_idx"}, {29'd0, gnt_idx_o}, {29'd0, exp_idx});
      chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, exp_busy});
      chk({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, exp_to});
   endtask

   // Wait (bounded) for the next grant and compare against the scoreboard head.
   task automatic wait_grant(input string tag, input int exp_lat);
      int lat;
      logic [2:0] e;
      logic [7:0] oh;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (gnt_valid_o !== 1'b1 && lat < 8);
      e = exp_q.pop_front();
      oh = 8'h01 << e;
      chk({tag, "_valid"}, {31'd0, gnt_valid_o}, 32'h1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_idx"}, {29'd0, gnt_idx_o}, {29'd0, e});
      chk({tag, "_gnt"}, {24'd0, gnt_o}, {24'd0, oh});
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'h1);
   endtask

   initial begin
      reset_i = 1'b1;
      req_i   = 8'h00;
      done_i  = 1'b0;
      #12;
      chk_idle_out("reset", 3'd0, 1'b0, 1'b0);
      reset_i = 1'b0;
      tick();

      // Single requester 2, then done with req drop in the same cycle.
      req_i = 8'h04;
      exp_q.push_back(3'd2);
      wait_grant("first", 1);
      done_i = 1'b1;
      req_i  = 8'h00;
      tick();
      done_i = 1'b0;
      chk_idle_out("rel_done", 3'd2, 1'b1, 1'b0);
      tick();
      chk_idle_out("idle_after", 3'd2, 1'b0, 1'b0);

      // ptr is now 3: with 2 and 4 pending, 4 wins.
      req_i = 8'h14;
      exp_q.push_back(3'd4);
      wait_grant("ptr3", 1);
      req_i = 8'h00;
      tick();
      tick();

      // All requesting: rotation from ptr=5 through every index.
      req_i = 8'hFF;
      for (int k = 0; k < 9; k++) exp_q.push_back(3'((5 + k) % 8));
      for (int k = 0; k < 9; k++) begin
         wait_grant($sformatf("rr%0d", k), (k == 0) ? 1 : 2);
         tick();
         done_i = 1'b1;
         if (k == 8) req_i = 8'h00;
         tick();
         done_i = 1'b0;
         chk($sformatf("rr%0d_relvalid", k), {31'd0, gnt_valid_o}, 32'h0);
      end
      tick();

      // Grant 5, withdraw request without done: release, no timeout, ptr=6.
      req_i = 8'h20;
      exp_q.push_back(3'd5);
      wait_grant("wd5", 1);
      tick();
      req_i = 8'h00;
      tick();
      chk_idle_out("wd5_rel", 3'd5, 1'b1, 1'b0);
      tick();
      req_i = 8'h60;
      exp_q.push_back(3'd6);
      wait_grant("ptr6", 1);
      req_i = 8'h00;
      tick();
      tick();

      // Watchdog: req[1] held alone, others join later; 1 re-granted last.
      req_i = 8'h02;
      exp_q.push_back(3'd1);
      wait_grant("to1", 1);
      req_i = 8'h4A;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("to_hold%0d", k), {31'd0, gnt_valid_o}, 32'h1);
         chk($sformatf("to_hold%0d_idx", k), {29'd0, gnt_idx_o}, 32'h1);
      end
      tick();
      chk_idle_out("to_rel", 3'd1, 1'b1, 1'b1);
      tick();
      chk_idle_out("to_idle", 3'd1, 1'b0, 1'b0);
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd1);
      wait_grant("after_to3", 1);
      done_i = 1'b1;
      req_i  = 8'h42;
      tick();
      done_i = 1'b0;
      wait_grant("after_to6", 2);
      done_i = 1'b1;
      req_i  = 8'h02;
      tick();
      done_i = 1'b0;
      wait_grant("regrant1", 2);

      // done coincides with watchdog expiry: done wins, no timeout pulse.
      tick();
      tick();
      tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      req_i  = 8'h00;
      chk_idle_out("done_wd", 3'd1, 1'b1, 1'b0);
      tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk_idle_out("done_idle", 3'd1, 1'b0, 1'b0);

      // Reset mid-grant drops the grant asynchronously and clears ptr.
      req_i = 8'h10;
      exp_q.push_back(3'd4);
      wait_grant("pre_rst", 1);
      #3;
      reset_i = 1'b1;
      #1;
      chk_idle_out("async_rst", 3'd0, 1'b0, 1'b0);
      #2;
      reset_i = 1'b0;
      req_i   = 8'h81;
      exp_q.push_back(3'd0);
      wait_grant("post_rst", 1);
      done_i = 1'b1;
      req_i  = 8'h00;
      tick();
      done_i = 1'b0;
      tick();

      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
